// File: rtl/sum_sq_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sum_sq_stream_pkg
// Description : Constants shared with the downstream CORDIC square-root block,
//               plus the accumulation FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package sum_sq_stream_pkg;

    // Output width shared with the sqrt block's N input.
    localparam int c_sqrt_width = 16;
    // Default signed element width.
    localparam int c_in_width   = 8;

    // Accumulation FSM.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

endpackage : sum_sq_stream_pkg
`default_nettype wire

// File: rtl/sum_sq_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : sum_sq_stream_if
// Description : Element stream in, norm result out, for sum_sq_stream.
//   elem_in    : signed vector element
//   elem_valid : element present this cycle
//   elem_last  : final element of the vector, qualified by elem_valid
//   N          : unsigned saturated sum of squares
//   N_valid    : one-cycle pulse marking N valid
//   sat        : true sum exceeded 2^WIDTH-1 (qualified by N_valid)
//   len_err    : vector force-terminated at MAX_LEN (qualified by N_valid)
//   busy       : a vector is partially accumulated
// Revision    : 1.0 - initial release
// ============================================================================
interface sum_sq_stream_if #(
    parameter int WIDTH    = 16,
    parameter int IN_WIDTH = 8
);
    logic signed [IN_WIDTH-1:0] elem_in;
    logic                       elem_valid;
    logic                       elem_last;
    logic        [WIDTH-1:0]    N;
    logic                       N_valid;
    logic                       sat;
    logic                       len_err;
    logic                       busy;

    // Element producer side.
    modport master (
        output elem_in, elem_valid, elem_last,
        input  N, N_valid, sat, len_err, busy
    );

    // Accumulator side.
    modport slave (
        input  elem_in, elem_valid, elem_last,
        output N, N_valid, sat, len_err, busy
    );
endinterface : sum_sq_stream_if
`default_nettype wire

// File: rtl/sum_sq_stream_sq_unit.sv
`default_nettype none
// ============================================================================
// Module      : sq_unit
// Description : Registered signed squarer. Produces the unsigned square of a
//               two's-complement input one cycle later. The square of the most
//               negative input, 2^(2*IN_WIDTH-2), still fits in 2*IN_WIDTH bits.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   i_a  : signed operand
//   o_sq : registered unsigned square
// Revision    : 1.0 - initial release
// ============================================================================
module sq_unit #(
    parameter int IN_WIDTH = 8
) (
    input  wire logic                        clk,
    input  wire logic                        rst,
    input  wire logic signed [IN_WIDTH-1:0]  i_a,
    output      logic        [2*IN_WIDTH-1:0] o_sq
);

    logic signed [2*IN_WIDTH-1:0] w_prod;
    logic        [2*IN_WIDTH-1:0] r_sq;

    // Operands are sign-extended to the product width before multiplying.
    assign w_prod = i_a * i_a;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sq <= '0;
        end else begin
            // A square is never negative, so reinterpretation is lossless.
            r_sq <= $unsigned(w_prod);
        end
    end

    assign o_sq = r_sq;

endmodule : sq_unit
`default_nettype wire

// File: rtl/sum_sq_stream.sv
`default_nettype none
// ============================================================================
// Module      : sum_sq_stream
// Description : Squares each signed element of a vector stream and emits the
//               per-vector sum of squares, saturated to WIDTH bits, with a
//               one-cycle valid pulse two cycles after the ending element.
//               Accepts one element per cycle, no backpressure.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   s   : element stream in / norm result out (slave modport)
// Revision    : 1.0 - initial release
// ============================================================================
module sum_sq_stream
    import sum_sq_stream_pkg::*;
#(
    parameter int WIDTH    = c_sqrt_width,
    parameter int IN_WIDTH = c_in_width,
    parameter int MAX_LEN  = 64,
    parameter int CNT_W    = $clog2(MAX_LEN + 1)
) (
    input wire logic       clk,
    input wire logic       rst,
    sum_sq_stream_if.slave s
);

    // Accumulator holds MAX_LEN worst-case squares without wrapping.
    localparam int c_acc_w = 2 * IN_WIDTH + CNT_W;

    // ---------------------------------------------------------------- stage 1
    logic [CNT_W-1:0]      r_cnt;
    logic                  w_at_max;
    logic                  w_end;
    logic [2*IN_WIDTH-1:0] w_sq1;
    logic                  r_v1;
    logic                  r_end1;
    logic                  r_lerr1;

    assign w_at_max = (r_cnt == CNT_W'(MAX_LEN - 1));
    // An accepted element ends the vector on last or on reaching MAX_LEN.
    assign w_end    = s.elem_valid & (s.elem_last | w_at_max);

    sq_unit #(
        .IN_WIDTH (IN_WIDTH)
    ) u_sq (
        .clk  (clk),
        .rst  (rst),
        .i_a  (s.elem_in),
        .o_sq (w_sq1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_end1  <= 1'b0;
            r_lerr1 <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_v1    <= s.elem_valid;
            r_end1  <= w_end;
            r_lerr1 <= s.elem_valid & ~s.elem_last & w_at_max;
            if (s.elem_valid) begin
                r_cnt <= w_end ? '0 : r_cnt + CNT_W'(1);
            end
        end
    end

    // ---------------------------------------------------------------- FSM
    state_t r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else if (s.elem_valid) begin
            // Single-element vectors never leave IDLE; gaps hold the state.
            r_state <= w_end ? IDLE : ACCUM;
        end
    end

    assign s.busy = (r_state == ACCUM);

    // ---------------------------------------------------------------- stage 2
    logic [c_acc_w-1:0] r_acc;
    logic [c_acc_w-1:0] w_sum;
    logic               w_over;
    logic [WIDTH-1:0]   w_low;
    logic [WIDTH-1:0]   r_n;
    logic               r_n_valid;
    logic               r_sat;
    logic               r_len_err;

    assign w_sum = r_acc + c_acc_w'(w_sq1);

    // Saturation is only possible when the accumulator is wider than N.
    if (c_acc_w > WIDTH) begin : g_sat_chk
        assign w_over = |w_sum[c_acc_w-1:WIDTH];
        assign w_low  = w_sum[WIDTH-1:0];
    end else begin : g_no_sat
        assign w_over = 1'b0;
        assign w_low  = WIDTH'(w_sum);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc     <= '0;
            r_n       <= '0;
            r_n_valid <= 1'b0;
            r_sat     <= 1'b0;
            r_len_err <= 1'b0;
        end else if (r_v1) begin
            if (r_end1) begin
                r_n       <= w_over ? {WIDTH{1'b1}} : w_low;
                r_sat     <= w_over;
                r_len_err <= r_lerr1;
                r_n_valid <= 1'b1;
                r_acc     <= '0;
            end else begin
                r_acc     <= w_sum;
                r_n_valid <= 1'b0;
            end
        end else begin
            // N, sat and len_err hold; they are only meaningful with N_valid.
            r_n_valid <= 1'b0;
        end
    end

    assign s.N       = r_n;
    assign s.N_valid = r_n_valid;
    assign s.sat     = r_sat;
    assign s.len_err = r_len_err;

endmodule : sum_sq_stream
`default_nettype wire

// File: tb/tb_sum_sq_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_sum_sq_stream
// Description : Self-checking bench for sum_sq_stream (WIDTH=16, IN_WIDTH=8,
//               MAX_LEN=4). A vector-level reference model computes each
//               expected result, which must appear two cycles after the
//               ending element.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_sq_stream;

    localparam int WIDTH    = 16;
    localparam int IN_WIDTH = 8;
    localparam int MAX_LEN  = 4;
    localparam int NMAX     = (1 << WIDTH) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sum_sq_stream_if #(.WIDTH(WIDTH), .IN_WIDTH(IN_WIDTH)) bus ();

    sum_sq_stream #(
        .WIDTH    (WIDTH),
        .IN_WIDTH (IN_WIDTH),
        .MAX_LEN  (MAX_LEN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .s   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit valid;
        int n;
        bit sat;
        bit lerr;
    } res_t;

    int   checks = 0;
    int   errors = 0;

    // Reference model: vector in progress and results in flight.
    int   m_len  = 0;
    longint m_sum = 0;
    res_t pipe [2];

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_clear();
        m_len = 0;
        m_sum = 0;
        for (int i = 0; i < 2; i++) pipe[i] = '{valid: 1'b0, n: 0, sat: 1'b0, lerr: 1'b0};
    endtask

    // One clock of stimulus followed by a mid-cycle check of the outputs.
    task automatic step(input bit v, input int d, input bit l);
        logic signed [IN_WIDTH-1:0] e;
        res_t now;
        bit   exp_busy;
        e = IN_WIDTH'(d);
        @(posedge clk);
        #1;
        bus.elem_valid = v;
        bus.elem_in    = e;
        bus.elem_last  = l;

        exp_busy = (m_len != 0);
        now = '{valid: 1'b0, n: 0, sat: 1'b0, lerr: 1'b0};
        if (v) begin
            m_len++;
            m_sum += longint'(e) * longint'(e);
            if (l || m_len == MAX_LEN) begin
                now.valid = 1'b1;
                now.sat   = (m_sum > NMAX);
                now.n     = now.sat ? NMAX : int'(m_sum);
                now.lerr  = !l;
                m_len = 0;
                m_sum = 0;
            end
        end

        @(negedge clk);
        chk("N_valid", int'(bus.N_valid), int'(pipe[1].valid));
        chk("busy", int'(bus.busy), int'(exp_busy));
        if (pipe[1].valid) begin
            chk("N", int'(bus.N), pipe[1].n);
            chk("sat", int'(bus.sat), int'(pipe[1].sat));
            chk("len_err", int'(bus.len_err), int'(pipe[1].lerr));
        end
        pipe[1] = pipe[0];
        pipe[0] = now;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0);
    endtask

    // One-cycle asynchronous reset asserted mid-cycle.
    task automatic reset_pulse();
        @(posedge clk);
        #1;
        bus.elem_valid = 1'b0;
        bus.elem_last  = 1'b0;
        bus.elem_in    = '0;
        #2 rst = 1'b1;
        #1;
        chk("rst_N_valid", int'(bus.N_valid), 0);
        chk("rst_N", int'(bus.N), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_sat", int'(bus.sat), 0);
        chk("rst_len_err", int'(bus.len_err), 0);
        @(posedge clk);
        #3 rst = 1'b0;
        model_clear();
    endtask

    initial begin
        bus.elem_valid = 1'b0;
        bus.elem_last  = 1'b0;
        bus.elem_in    = '0;
        model_clear();

        // Reset state.
        #12;
        chk("init_N_valid", int'(bus.N_valid), 0);
        chk("init_N", int'(bus.N), 0);
        chk("init_busy", int'(bus.busy), 0);
        chk("init_sat", int'(bus.sat), 0);
        chk("init_len_err", int'(bus.len_err), 0);
        @(negedge clk);
        rst = 1'b0;

        // {3, 4(last)} -> 25.
        step(1, 3, 0); step(1, 4, 1); idle(3);

        // Saturation: four -128 -> 65536 saturates; then single -128 -> 16384.
        step(1, -128, 0); step(1, -128, 0); step(1, -128, 0); step(1, -128, 1);
        step(1, -128, 1); idle(3);

        // Back-to-back vectors with no gaps.
        step(1, 1, 0); step(1, 2, 1); step(1, 5, 1); step(1, 0, 1); idle(3);

        // Gap inside a vector.
        step(1, 6, 0); idle(3); step(1, 8, 1); idle(3);

        // Forced termination at MAX_LEN, then a new vector ending by last.
        for (int i = 0; i < 5; i++) step(1, 1, 0);
        step(1, 2, 1); idle(3);

        // Last exactly at MAX_LEN.
        step(1, 2, 0); step(1, 2, 0); step(1, 2, 0); step(1, -2, 1); idle(3);

        // Zero vector.
        step(1, 0, 0); step(1, 0, 1); idle(3);

        // last without valid is ignored.
        step(0, 50, 1); step(1, 7, 1); idle(3);

        // Reset mid-vector, then with an end still in flight.
        step(1, 9, 0); step(1, 9, 0); reset_pulse(); idle(3);
        step(1, 9, 0); step(1, 7, 1); reset_pulse(); idle(3);
        step(1, 1, 1); idle(3);

        // Randomised streams.
        for (int i = 0; i < 400; i++) begin
            int  d;
            bit  v;
            bit  l;
            v = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       d = -128;
                1:       d = 127;
                default: d = int'($urandom_range(0, 255)) - 128;
            endcase
            step(v, d, l);
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sum_sq_stream
`default_nettype wire

// File: doc/sum_sq_stream.md
Name: sum_sq_stream

Overview:
- Upstream feeder for the CORDIC square-root pipeline.
- Takes a stream of signed vector elements, squares each one and accumulates the squares per vector.
- Emits the squared Euclidean norm N as an unsigned integer, saturated to WIDTH bits, with a one-cycle valid pulse. N and N_valid connect directly to the sqrt block's N and in_valid.
- No backpressure: the sqrt pipeline accepts one input every cycle, so this block does too.

Parameters:
- WIDTH, 16: output width. Must equal the sqrt block's width.
- IN_WIDTH, 8: signed element width.
- MAX_LEN, 64: maximum number of elements per vector. Must be ≥ 1.
- CNT_W, derived = $clog2(MAX_LEN+1): width of the element counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- elem_in  in  IN_WIDTH  signed vector element
- elem_valid  in  1  element present this cycle
- elem_last  in  1  final element of the vector; qualified by elem_valid
- N  out  WIDTH  unsigned sum of squares, saturated
- N_valid  out  1  one-cycle pulse; N is valid in that cycle
- sat  out  1  qualified by N_valid; the true sum exceeded 2^WIDTH-1
- len_err  out  1  qualified by N_valid; vector was force-terminated at MAX_LEN
- busy  out  1  a vector is partially accumulated

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, named rst.
- Reset values: N=0, N_valid=0, sat=0, len_err=0, busy=0, state=IDLE. The accumulator, element counter and pipeline valid bits all clear.
- Stage 1 (input register), on every cycle:
  - sq1 <= elem_in*elem_in, unsigned, 2*IN_WIDTH bits. The square of -2^(IN_WIDTH-1) must fit.
  - v1 <= elem_valid.
  - end1 <= elem_valid & (elem_last | cnt==MAX_LEN-1).
  - lerr1 <= elem_valid & ~elem_last & cnt==MAX_LEN-1.
- Counter cnt:
  - Increments on each accepted element.
  - Clears to 0 on any accepted element that ends a vector.
  - Holds while elem_valid=0.
- Stage 2 (accumulate), when v1=1:
  - sum = acc + sq1. The accumulator is wide enough never to wrap: 2*IN_WIDTH+$clog2(MAX_LEN+1) bits.
  - If end1=1:
    - N <= (sum > 2^WIDTH-1) ? 2^WIDTH-1 : sum[WIDTH-1:0]
    - sat <= overflow; len_err <= lerr1; N_valid <= 1; acc <= 0.
  - Otherwise acc <= sum and N_valid <= 0.
- When v1=0: acc holds and N_valid <= 0. sat and len_err hold their last values; they are meaningful only while N_valid=1.
- Latency: N_valid is high in cycle t+2 when the ending element is accepted in cycle t. Throughput is one element per cycle.
- FSM, which drives busy:
  - IDLE → ACCUM: an accepted element does not end the vector.
  - IDLE → IDLE: a single-element vector (last on the first element) produces a result without entering ACCUM.
  - ACCUM → IDLE: an accepted element ends the vector, by last or by MAX_LEN.
  - ACCUM holds through gaps where elem_valid=0.
  - busy = (state==ACCUM).
- Back-to-back vectors: an element in the cycle after an end is the first element of the next vector. Consecutive N_valid pulses are legal.
- Forced termination: the MAX_LEN-th element without last ends the vector with len_err=1. The next element starts a new vector. A last arriving exactly at MAX_LEN gives len_err=0.
- Zero vector: every element 0 gives N=0 and N_valid=1. The downstream sqrt handles N=0.
- Reset mid-vector: the partial sum is discarded and no N_valid is produced. This includes an end that is in flight in stage 1 or stage 2.
- elem_last with elem_valid=0 is ignored.

Decomposition:
- Shared package: the element/output width constants common with the sqrt block (WIDTH=16), and the FSM state enum {IDLE, ACCUM}.
- One sub-module, sq_unit: registered signed squarer that outputs the unsigned square and is parameterised by IN_WIDTH. It forms stage 1's datapath so it can be reused by other norm-style blocks.
- Counter, FSM, accumulator and saturation stay in the top module.

Test Plan:
- IN_WIDTH=8, WIDTH=16: stream {3, 4(last)} on consecutive cycles → N=25, N_valid high exactly 2 cycles after the 4, sat=0, len_err=0.
- {-128,-128,-128,-128(last)} → true sum 65536, N=65535, sat=1. Then {-128(last)} → N=16384, sat=0.
- Back-to-back {1, 2(last)}, {5(last)}, {0(last)} with no gaps → N_valid on 3 consecutive... no: pulses 5 and 25 on consecutive cycles, then 0 on the next cycle. busy is high only during the first vector.
- {6, gap of 3 idle cycles, 8(last)} → N=100; busy stays 1 through the gap.
- MAX_LEN=4: five elements of value 1, none marked last → N=4 with len_err=1; the fifth element alone is held, busy=1. Then last with 2 → N=5, len_err=0.
- Assert rst for 1 cycle, asynchronous and mid-cycle, after {9, 9}, and also with a last in flight → no N_valid, outputs 0. Then {1(last)} → N=1.
